// File: rtl/rv_dm_arbiter.sv
// rv_dm_arbiter: shares one single-port data memory between the core data port
// and a host/debug port. One transaction in flight, round-robin on contention,
// optional per-transaction response timeout.
//
// Ports
//   clk_i, rst_i              clock, asynchronous active-high reset
//   dm_*                      core port: level load/store request, ready pulse
//   host_*                    host port: level request, ack pulse
//   mem_*                     memory side: one-cycle request strobe, valid response
module rv_dm_arbiter #(
  parameter int unsigned g_timeout = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_ready_o,
  output logic        dm_err_o,
  input  logic [31:0] host_addr_i,
  input  logic [31:0] host_data_i,
  input  logic        host_wr_i,
  input  logic        host_req_i,
  output logic [31:0] host_data_o,
  output logic        host_ack_o,
  output logic        host_err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_sel_o,
  output logic        mem_we_o,
  output logic        mem_req_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_valid_i
);

  localparam int unsigned CNT_W = 16;
  localparam bit TO_EN = (g_timeout != 0);
  localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(g_timeout - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic {P_CORE, P_HOST} port_t;

  state_t           state;
  port_t            grant;
  port_t            last_grant;
  logic             bad_q;
  logic [CNT_W-1:0] cnt;

  logic             core_req_c;
  logic             grant_host_c;
  logic             fin_c;
  logic             fin_err_c;
  logic [31:0]      fin_data_c;

  // Arbitration: a lone requester wins; on contention the port not served last wins.
  always_comb begin
    core_req_c   = dm_load_i | dm_store_i;
    grant_host_c = host_req_i & (~core_req_c | (last_grant == P_CORE));
  end

  // Completion detection and the response payload handed to the granted port.
  always_comb begin
    fin_c      = 1'b0;
    fin_err_c  = 1'b0;
    fin_data_c = '0;
    case (state)
      S_ISSUE: begin
        if (bad_q) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_valid_i) begin
          fin_c      = 1'b1;
          fin_data_c = mem_we_o ? '0 : mem_data_i;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          fin_c     = 1'b1;
          fin_err_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      grant       <= P_CORE;
      last_grant  <= P_HOST;
      bad_q       <= 1'b0;
      cnt         <= '0;
      dm_data_l_o <= '0;
      dm_ready_o  <= 1'b0;
      dm_err_o    <= 1'b0;
      host_data_o <= '0;
      host_ack_o  <= 1'b0;
      host_err_o  <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      mem_sel_o   <= '0;
      mem_we_o    <= 1'b0;
      mem_req_o   <= 1'b0;
    end else begin
      dm_ready_o <= 1'b0;
      dm_err_o   <= 1'b0;
      host_ack_o <= 1'b0;
      host_err_o <= 1'b0;

      if (fin_c) begin
        state      <= S_DONE;
        bad_q      <= 1'b0;
        mem_req_o  <= 1'b0;
        mem_addr_o <= '0;
        mem_data_o <= '0;
        mem_sel_o  <= '0;
        mem_we_o   <= 1'b0;
        if (grant == P_HOST) begin
          host_ack_o  <= 1'b1;
          host_err_o  <= fin_err_c;
          host_data_o <= fin_data_c;
        end else begin
          dm_ready_o  <= 1'b1;
          dm_err_o    <= fin_err_c;
          dm_data_l_o <= fin_data_c;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (core_req_c | host_req_i) begin
              state <= S_ISSUE;
              if (grant_host_c) begin
                grant      <= P_HOST;
                last_grant <= P_HOST;
                // Misaligned host access takes the ISSUE slot but never strobes memory.
                if (host_addr_i[1:0] != 2'b00) begin
                  bad_q <= 1'b1;
                end else begin
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= host_addr_i;
                  mem_data_o <= host_data_i;
                  mem_sel_o  <= 4'b1111;
                  mem_we_o   <= host_wr_i;
                end
              end else begin
                grant      <= P_CORE;
                last_grant <= P_CORE;
                mem_req_o  <= 1'b1;
                mem_addr_o <= dm_addr_i;
                mem_data_o <= dm_data_s_i;
                mem_sel_o  <= dm_data_select_i;
                mem_we_o   <= dm_store_i;
              end
            end
          end
          S_ISSUE: begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT;
          end
          S_WAIT: begin
            cnt <= cnt + CNT_W'(1);
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
